// File: rtl/sc_fifo_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sc_fifo_shifter_pkg
// Description : Shared slow-control definitions: frame geometry and the
//               FIFO-to-ASIC shifter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sc_fifo_shifter_pkg;

  // Frame geometry, shared with the frame builder
  localparam int SC_FRAME_BITS  = 616;
  localparam int SC_FRAME_BYTES = SC_FRAME_BITS / 8;

  // Shifter states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_SHIFT = 3'd4,
    ST_DONE  = 3'd5
  } sc_state_e;

endpackage
`default_nettype wire

// File: rtl/sc_clk_phase.sv
`default_nettype none
// ============================================================================
// Module      : sc_clk_phase
// Description : Half-period counter for the serial clock. Counts a low phase
//               then a high phase of HALF_PERIOD cycles each, and strobes the
//               last cycle of each phase. Held at zero while disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module sc_clk_phase #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic phase_high_o,
  output logic last_low_o,
  output logic last_high_o
);

  localparam int C_CNT_W = $clog2(2 * HALF_PERIOD);
  localparam logic [C_CNT_W-1:0] C_HALF      = C_CNT_W'(HALF_PERIOD);
  localparam logic [C_CNT_W-1:0] C_LAST_LOW  = C_CNT_W'(HALF_PERIOD - 1);
  localparam logic [C_CNT_W-1:0] C_LAST_HIGH = C_CNT_W'(2 * HALF_PERIOD - 1);

  logic [C_CNT_W-1:0] cnt_q;
  logic [C_CNT_W-1:0] cnt_d;

  // Wrap at the end of the high phase; restart from the low phase when idle
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en_i || (cnt_q == C_LAST_HIGH)) begin
      cnt_d = '0;
    end
  end

  // Phase counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_high_o = en_i && (cnt_q >= C_HALF);
  assign last_low_o   = en_i && (cnt_q == C_LAST_LOW);
  assign last_high_o  = en_i && (cnt_q == C_LAST_HIGH);

endmodule
`default_nettype wire

// File: rtl/sc_fifo_shifter.sv
`default_nettype none
// ============================================================================
// Module      : sc_fifo_shifter
// Description : Pops a slow-control frame from the external FIFO, shifts it
//               MSB-first into the ASIC SC chain on a divided clock, and packs
//               the chain output into bytes for the readback FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module sc_fifo_shifter
  import sc_fifo_shifter_pkg::*;
#(
  parameter int SC_BYTES    = SC_FRAME_BYTES,
  parameter int HALF_PERIOD = 4,
  parameter int TIMEOUT     = 1023
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start_In,
  input  logic       In_Fifo_Empty,
  input  logic [7:0] In_Fifo_Dout,
  output logic       Out_Fifo_Rd_En,
  output logic       Out_Sr_Ck,
  output logic       Out_Sr_In,
  input  logic       In_Sr_Out,
  output logic       Out_Rb_Fifo_Wr_En,
  output logic [7:0] Out_Rb_Fifo_Din,
  output logic       Out_Busy,
  output logic       Out_Error,
  output logic       End_Flag
);

  localparam int C_BYTE_W = $clog2(SC_BYTES + 1);
  localparam int C_TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [C_BYTE_W-1:0] C_LAST_BYTE = C_BYTE_W'(SC_BYTES - 1);
  localparam logic [C_TO_W-1:0]   C_TO_LAST   = C_TO_W'(TIMEOUT - 1);

  sc_state_e           state_q, state_d;
  logic                start_dly_q;
  logic [C_TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [C_BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]          sreg_q, sreg_d;
  logic [7:0]          rb_q, rb_d;
  logic                rd_en_q, rd_en_d;
  logic                wr_en_q, wr_en_d;
  logic                err_q, err_d;
  logic                sr_ck_q, sr_ck_d;
  logic                sr_in_q, sr_in_d;

  logic w_start_edge;
  logic w_phase_high;
  logic w_last_low;
  logic w_last_high;

  assign w_start_edge = Start_In && !start_dly_q;

  sc_clk_phase #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_clk_phase (
    .clk          (Clk),
    .rst          (Rst),
    .en_i         (state_q == ST_SHIFT),
    .phase_high_o (w_phase_high),
    .last_low_o   (w_last_low),
    .last_high_o  (w_last_high)
  );

  // Next-state, counters and datapath
  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    sreg_d     = sreg_q;
    rb_d       = rb_q;
    rd_en_d    = 1'b0;
    wr_en_d    = 1'b0;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        if (w_start_edge) begin
          state_d    = ST_FETCH;
          err_d      = 1'b0;
          byte_cnt_d = '0;
          to_cnt_d   = '0;
        end
      end
      ST_FETCH: begin
        if (!In_Fifo_Empty) begin
          rd_en_d  = 1'b1;
          to_cnt_d = '0;
          state_d  = ST_WAIT;
        end else if (to_cnt_q == C_TO_LAST) begin
          // This is the TIMEOUT-th consecutive empty cycle
          err_d    = 1'b1;
          to_cnt_d = '0;
          state_d  = ST_DONE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        sreg_d    = In_Fifo_Dout;
        bit_cnt_d = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_last_high) begin
          rb_d      = {rb_q[6:0], In_Sr_Out};
          sreg_d    = {sreg_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            wr_en_d    = 1'b1;
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = (byte_cnt_q == C_LAST_BYTE) ? ST_DONE : ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Serial pins are registered so the ASIC sees glitch-free levels
    sr_ck_d = w_last_low || (w_phase_high && !w_last_high);
    sr_in_d = (state_d == ST_SHIFT) ? sreg_d[7] : 1'b0;
  end

  // State and datapath registers; start-edge register resets high
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      start_dly_q <= 1'b1;
      to_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      sreg_q      <= '0;
      rb_q        <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      err_q       <= 1'b0;
      sr_ck_q     <= 1'b0;
      sr_in_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_dly_q <= Start_In;
      to_cnt_q    <= to_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      sreg_q      <= sreg_d;
      rb_q        <= rb_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      err_q       <= err_d;
      sr_ck_q     <= sr_ck_d;
      sr_in_q     <= sr_in_d;
    end
  end

  assign Out_Fifo_Rd_En    = rd_en_q;
  assign Out_Sr_Ck         = sr_ck_q;
  assign Out_Sr_In         = sr_in_q;
  assign Out_Rb_Fifo_Wr_En = wr_en_q;
  assign Out_Rb_Fifo_Din   = rb_q;
  assign Out_Busy          = (state_q != ST_IDLE);
  assign Out_Error         = err_q;
  assign End_Flag          = (state_q == ST_DONE);

endmodule
`default_nettype wire
